// File: rtl/rd_ptr_ctrl_if.sv
// Read-side pointer bus between the consumer/empty generator and rd_ptr_ctrl.
interface rd_ptr_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          rd_en;
    logic          empty;
    logic          rd_ack;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] ptr_next;
    logic [AW-1:0] rptr_gray;
    logic [AW-1:0] wptr_gray_async;
    logic [AW-1:0] wptr_sync;
    logic          underflow;

    // Consumer / empty-generator side.
    modport master (
        output rd_en,
        output empty,
        output wptr_gray_async,
        input  rd_ack,
        input  rd_addr,
        input  ptr_next,
        input  rptr_gray,
        input  wptr_sync,
        input  underflow
    );

    // Pointer controller side.
    modport slave (
        input  rd_en,
        input  empty,
        input  wptr_gray_async,
        output rd_ack,
        output rd_addr,
        output ptr_next,
        output rptr_gray,
        output wptr_sync,
        output underflow
    );
endinterface

// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer manager for the dual-clock FIFO: owns the binary read
// pointer, exports it as Gray code, and synchronizes the Gray write pointer.
module rd_ptr_ctrl #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          resetn,
    rd_ptr_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_rptr_gray;
    logic          r_underflow;
    logic [AW-1:0] r_wsync [SYNC_STAGES];

    logic          w_rd_ack;
    logic [AW-1:0] w_ptr_next;
    logic [AW-1:0] w_wptr_bin;

    // Accept a pop only when data is present; pointer wraps naturally at AW bits.
    always_comb begin
        w_rd_ack   = bus.rd_en & ~bus.empty;
        w_ptr_next = r_rptr + {{(AW-1){1'b0}}, w_rd_ack};
    end

    // Binary read pointer and its Gray image advance together so they never disagree.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rptr      <= '0;
            r_rptr_gray <= '0;
        end else begin
            r_rptr      <= w_ptr_next;
            r_rptr_gray <= w_ptr_next ^ (w_ptr_next >> 1);
        end
    end

    // Sticky flag: a pop request seen while empty is an error until reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_underflow <= 1'b0;
        end else if (bus.rd_en && bus.empty) begin
            r_underflow <= 1'b1;
        end
    end

    // Plain flop chain for the asynchronous Gray write pointer; no logic between stages.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wsync[i] <= '0;
            end
        end else begin
            r_wsync[0] <= bus.wptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wsync[i] <= r_wsync[i-1];
            end
        end
    end

    // Gray-to-binary on the last sync stage: bit i is the XOR of gray bits AW-1..i.
    always_comb begin
        w_wptr_bin = '0;
        for (int i = 0; i < AW; i++) begin
            w_wptr_bin[i] = ^(r_wsync[SYNC_STAGES-1] >> i);
        end
    end

    assign bus.rd_ack    = w_rd_ack;
    assign bus.rd_addr   = r_rptr;
    assign bus.ptr_next  = w_ptr_next;
    assign bus.rptr_gray = r_rptr_gray;
    assign bus.wptr_sync = w_wptr_bin;
    assign bus.underflow = r_underflow;
endmodule
